// File: rtl/sm_clk_debug_ctrl.sv
// Run-control and debug block for sm_top: programmable clock enable, halt/run/step
// modes with a debounced step key, retired-cycle counter and paged LED readout.
module sm_clk_debug_ctrl #(
  parameter int unsigned DIV_W      = 4,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned LED_W      = 10,
  parameter int unsigned PAGE_W     = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clkIn,
  input  logic              rst_p,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  clkDevide,
  input  logic              stepKey,
  input  logic [ADDR_W-1:0] regAddrIn,
  input  logic [PAGE_W-1:0] pageSel,
  input  logic [DATA_W-1:0] regData,
  output logic              cpuEn,
  output logic [ADDR_W-1:0] regAddr,
  output logic [LED_W-1:0]  ledOut,
  output logic [CNT_W-1:0]  cycleCnt,
  output logic              stepBusy
);

  localparam int unsigned DEB_W    = $clog2(DEB_CYCLES);
  localparam int unsigned PAGE_SPAN = LED_W << PAGE_W;
  localparam int unsigned PAD_W    = (PAGE_SPAN > DATA_W) ? PAGE_SPAN : DATA_W;

  typedef enum logic [1:0] {HALT, RUN, STEP_ARM, STEP_PULSE} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   period;
  logic               sync1, sync2, deb, step_req;
  logic [DEB_W-1:0]   deb_cnt;
  logic               deb_fire;
  logic               req_next;
  logic [PAD_W-1:0]   padded;

  // Debounced level follows the synced key only after DEB_CYCLES consecutive cycles of disagreement.
  assign deb_fire = (sync2 != deb) && (deb_cnt == DEB_W'(DEB_CYCLES - 1));
  assign req_next = deb_fire && sync2;

  always_ff @(posedge clkIn) begin
    if (rst_p) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb      <= 1'b0;
      deb_cnt  <= '0;
      step_req <= 1'b0;
    end else begin
      sync1    <= stepKey;
      sync2    <= sync1;
      step_req <= req_next;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_fire) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // stepBusy is raised together with step_req so it covers the request cycle and the pulse.
  always_ff @(posedge clkIn) begin
    if (rst_p) begin
      state    <= HALT;
      div_cnt  <= '0;
      period   <= '0;
      cpuEn    <= 1'b0;
      stepBusy <= 1'b0;
      cycleCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + CNT_W'(cpuEn);
      cpuEn    <= 1'b0;
      stepBusy <= req_next && (mode == 2'd2);
      case (state)
        RUN: begin
          if (mode == 2'd1) begin
            if (div_cnt == period) begin
              div_cnt <= '0;
              period  <= clkDevide;
              cpuEn   <= (clkDevide == '0);
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
              cpuEn   <= ((div_cnt + DIV_W'(1)) == period);
            end
          end else begin
            div_cnt <= '0;
            state   <= (mode == 2'd2) ? STEP_ARM : HALT;
          end
        end
        STEP_ARM: begin
          if (mode == 2'd2) begin
            if (step_req) begin
              state    <= STEP_PULSE;
              cpuEn    <= 1'b1;
              stepBusy <= 1'b1;
            end
          end else if (mode == 2'd1) begin
            state  <= RUN;
            period <= clkDevide;
            cpuEn  <= (clkDevide == '0);
          end else begin
            state <= HALT;
          end
        end
        default: begin
          // HALT and STEP_PULSE share the same mode-driven exit.
          div_cnt <= '0;
          if (mode == 2'd1) begin
            state  <= RUN;
            period <= clkDevide;
            cpuEn  <= (clkDevide == '0);
          end else if (mode == 2'd2) begin
            state <= STEP_ARM;
          end else begin
            state <= HALT;
          end
        end
      endcase
    end
  end

  always_comb begin
    padded = '0;
    padded[DATA_W-1:0] = regData;
  end

  always_ff @(posedge clkIn) begin
    if (rst_p) begin
      regAddr <= '0;
      ledOut  <= '0;
    end else begin
      regAddr <= regAddrIn;
      ledOut  <= padded[pageSel * LED_W +: LED_W];
    end
  end

endmodule
